// File: rtl/mem_bus_arbiter.sv
// Two-requester (instruction fetch / data) arbiter onto one memory port, one transaction in flight.
// Optional macro MEM_ARB_RR_EN: round-robin on collisions instead of fixed data-side priority.
module mem_bus_arbiter #(
    parameter int AW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic          i_addr_ok,
    output logic          i_data_ok,
    output logic [31:0]   i_rdata,
    input  logic          d_req,
    input  logic          d_wr,
    input  logic [1:0]    d_size,
    input  logic [3:0]    d_wstrb,
    input  logic [AW-1:0] d_addr,
    input  logic [31:0]   d_wdata,
    output logic          d_addr_ok,
    output logic          d_data_ok,
    output logic [31:0]   d_rdata,
    output logic          m_req,
    output logic          m_wr,
    output logic [1:0]    m_size,
    output logic [3:0]    m_wstrb,
    output logic [AW-1:0] m_addr,
    output logic [31:0]   m_wdata,
    input  logic          m_addr_ok,
    input  logic          m_data_ok,
    input  logic [31:0]   m_rdata,
    output logic          busy
);
    typedef enum logic [1:0] {IDLE, ADDR, WAIT} state_t;

    state_t state, state_nx;
    logic   owner;      // 0 = instruction side, 1 = data side
    logic   take;
    logic   grant_d;

    assign take = (state == IDLE) && (i_req || d_req);

`ifdef MEM_ARB_RR_EN
    logic last_d;

    // On a collision the side that did not win last time goes first.
    assign grant_d = d_req && (!i_req || !last_d);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)      last_d <= 1'b0;
        else if (take) last_d <= grant_d;
    end
`else
    assign grant_d = d_req;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner   <= 1'b0;
            m_wr    <= 1'b0;
            m_size  <= 2'd0;
            m_wstrb <= 4'd0;
            m_addr  <= '0;
            m_wdata <= 32'd0;
        end else if (take) begin
            owner <= grant_d;
            if (grant_d) begin
                m_wr    <= d_wr;
                m_size  <= d_size;
                m_wstrb <= d_wstrb;
                m_addr  <= d_addr;
                m_wdata <= d_wdata;
            end else begin
                m_wr    <= 1'b0;
                m_size  <= 2'd2;
                m_wstrb <= 4'd0;
                m_addr  <= i_addr;
                m_wdata <= 32'd0;
            end
        end
    end

    always_comb begin
        state_nx  = state;
        m_req     = 1'b0;
        i_addr_ok = 1'b0;
        d_addr_ok = 1'b0;
        i_data_ok = 1'b0;
        d_data_ok = 1'b0;
        case (state)
            IDLE: if (take) state_nx = ADDR;
            ADDR: begin
                m_req = 1'b1;
                if (m_addr_ok) begin
                    i_addr_ok = !owner;
                    d_addr_ok = owner;
                    // Completion in the accept cycle skips WAIT entirely.
                    if (m_data_ok) begin
                        i_data_ok = !owner;
                        d_data_ok = owner;
                        state_nx  = IDLE;
                    end else begin
                        state_nx  = WAIT;
                    end
                end
            end
            WAIT: begin
                if (m_data_ok) begin
                    i_data_ok = !owner;
                    d_data_ok = owner;
                    state_nx  = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign busy    = (state != IDLE);
    // Read data is a pass-through; forced low only while reset is asserted.
    assign i_rdata = rst ? m_rdata : 32'd0;
    assign d_rdata = rst ? m_rdata : 32'd0;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed scenarios plus a randomized run,
// all cycles checked against a transaction-level model of the arbiter.
module tb_mem_bus_arbiter;
    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          i_req = 1'b0, d_req = 1'b0, d_wr = 1'b0;
    logic [AW-1:0] i_addr = '0, d_addr = '0;
    logic [1:0]    d_size = 2'd0;
    logic [3:0]    d_wstrb = 4'd0;
    logic [31:0]   d_wdata = 32'd0, m_rdata = 32'h1234_5678;
    logic          m_addr_ok = 1'b0, m_data_ok = 1'b0;
    logic          i_addr_ok, i_data_ok, d_addr_ok, d_data_ok, m_req, m_wr, busy;
    logic [31:0]   i_rdata, d_rdata, m_wdata;
    logic [1:0]    m_size;
    logic [3:0]    m_wstrb;
    logic [AW-1:0] m_addr;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_bus_arbiter #(.AW(AW)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_addr_ok(i_addr_ok), .i_data_ok(i_data_ok), .i_rdata(i_rdata),
        .d_req(d_req), .d_wr(d_wr), .d_size(d_size), .d_wstrb(d_wstrb), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_addr_ok(d_addr_ok), .d_data_ok(d_data_ok), .d_rdata(d_rdata),
        .m_req(m_req), .m_wr(m_wr), .m_size(m_size), .m_wstrb(m_wstrb), .m_addr(m_addr),
        .m_wdata(m_wdata), .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok), .m_rdata(m_rdata),
        .busy(busy)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Transaction-level model: a transaction exists from grant to completion,
    // and is "accepted" once the memory took its address.
    bit          txn, acc, own, last_d, win_d;
    bit          e_aok, e_done;
    logic [38:0] e_pay;
    logic [31:0] e_wdata;
    int          n_iaok, n_daok, n_idok, n_ddok;
    bit          glog[$];

    always @(negedge clk) begin
        if (!rst) begin
            chk("rst_ctrl", {m_req, m_wr, m_size, m_wstrb, busy, i_addr_ok, i_data_ok, d_addr_ok, d_data_ok}, 0);
            chk("rst_addr", {m_addr, m_wdata}, 0);
            chk("rst_rdata", {i_rdata, d_rdata}, 0);
            txn = 0; acc = 0; own = 0; last_d = 0;
        end else begin
            e_aok  = txn && !acc && m_addr_ok;
            e_done = txn && m_data_ok && (acc || m_addr_ok);
            chk("m_req", m_req, txn && !acc);
            chk("busy", busy, txn);
            chk("i_addr_ok", i_addr_ok, e_aok && !own);
            chk("d_addr_ok", d_addr_ok, e_aok && own);
            chk("i_data_ok", i_data_ok, e_done && !own);
            chk("d_data_ok", d_data_ok, e_done && own);
            chk("rdata", {i_rdata, d_rdata}, {m_rdata, m_rdata});
            if (txn) chk("payload", {m_wr, m_size, m_wstrb, m_addr}, e_pay);
            if (txn && own) chk("wdata", m_wdata, e_wdata);
            if (i_addr_ok) begin n_iaok++; glog.push_back(1'b0); end
            if (d_addr_ok) begin n_daok++; glog.push_back(1'b1); end
            if (i_data_ok) n_idok++;
            if (d_data_ok) n_ddok++;
            if (!txn) begin
                if (i_req || d_req) begin
`ifdef MEM_ARB_RR_EN
                    win_d = (i_req && d_req) ? !last_d : d_req;
`else
                    win_d = d_req;
`endif
                    last_d  = win_d;
                    own     = win_d;
                    txn     = 1; acc = 0;
                    e_pay   = win_d ? {d_wr, d_size, d_wstrb, d_addr} : {1'b0, 2'd2, 4'd0, i_addr};
                    e_wdata = d_wdata;
                end
            end else if (e_done) begin
                txn = 0;
            end else if (e_aok) begin
                acc = 1;
            end
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic clr_cnt();
        n_iaok = 0; n_daok = 0; n_idok = 0; n_ddok = 0;
        glog.delete();
    endtask

    // Simple memory: accept immediately, complete in the following cycle.
    task automatic auto_cycles(input int n, input bit hold);
        bit hi, hd;
        for (int k = 0; k < n; k++) begin
            m_addr_ok = m_req;
            m_data_ok = busy && !m_req;
            m_rdata   = $urandom;
            #1; hi = i_addr_ok; hd = d_addr_ok;
            step();
            if (!hold) begin
                if (hi) i_req = 0;
                if (hd) d_req = 0;
            end
        end
    endtask

    initial begin
        bit hi, hd;
        bit [2:0] exp_cont;
        step(); step();
        chk("reset_busy", busy, 0);
        chk("reset_rdata_gate", i_rdata, 0);
        rst = 1;
        step();

        // Single data load through the full ADDR/WAIT sequence.
        clr_cnt();
        d_req = 1; d_wr = 0; d_size = 2; d_wstrb = 0; d_addr = 32'h1000;
        step();
        #1 chk("load_mreq", m_req, 1);
        chk("load_maddr", m_addr, 32'h1000);
        step(); m_addr_ok = 1;
        #1 chk("load_daok", d_addr_ok, 1);
        step(); d_req = 0; m_addr_ok = 0;
        step(); step();
        m_data_ok = 1; m_rdata = 32'hDEADBEEF;
        #1 chk("load_ddok", d_data_ok, 1);
        chk("load_rdata", d_rdata, 32'hDEADBEEF);
        step(); m_data_ok = 0;
        step();
        chk("load_counts", {n_daok[7:0], n_ddok[7:0], n_iaok[7:0], n_idok[7:0]}, 32'h01010000);
        chk("load_idle", busy, 0);

        // Store payload held stable until the address is accepted.
        d_req = 1; d_wr = 1; d_size = 1; d_wstrb = 4'h3; d_wdata = 32'h0000ABCD; d_addr = 32'h2004;
        step();
        for (int k = 0; k < 4; k++) begin
            m_addr_ok = (k == 3);
            #1 chk("store_pay", {m_req, m_wr, m_size, m_wstrb, m_wdata}, {1'b1, 1'b1, 2'd1, 4'h3, 32'h0000ABCD});
            step();
        end
        d_req = 0; m_addr_ok = 0; m_data_ok = 1;
        step(); m_data_ok = 0;
        step();

        // Accept and completion in the same ADDR cycle, next grant right after.
        d_req = 1; d_wr = 0; d_size = 0; d_addr = 32'h3001;
        step();
        m_addr_ok = 1; m_data_ok = 1;
        #1 chk("same_cyc_ok", {d_addr_ok, d_data_ok}, 2'b11);
        step(); d_req = 0; m_addr_ok = 0; m_data_ok = 0; i_req = 1; i_addr = 32'h80;
        #1 chk("same_cyc_idle", busy, 0);
        step();
        #1 chk("same_cyc_regrant", {m_req, m_addr}, {1'b1, 32'h80});
        m_addr_ok = 1; m_data_ok = 1;
        step(); i_req = 0; m_addr_ok = 0; m_data_ok = 0;
        step();

        // One-shot collision: data first, instruction after.
        clr_cnt();
        i_req = 1; i_addr = 32'h100; d_req = 1; d_wr = 0; d_size = 2; d_addr = 32'h200;
        auto_cycles(12, 0);
        chk("coll_cnt", glog.size(), 2);
        chk("coll_order", {glog[0], glog[1]}, 2'b10);

        // Continuous collisions: three grants.
        clr_cnt();
        i_req = 1; d_req = 1;
        auto_cycles(9, 1);
        i_req = 0; d_req = 0;
        auto_cycles(4, 0);
`ifdef MEM_ARB_RR_EN
        exp_cont = 3'b101;
`else
        exp_cont = 3'b111;
`endif
        chk("cont_cnt_ge3", glog.size() >= 3, 1);
        chk("cont_order", {glog[0], glog[1], glog[2]}, exp_cont);

        // Reset while waiting for data drops the transaction.
        clr_cnt();
        d_req = 1; d_addr = 32'h3000;
        step(); m_addr_ok = 1;
        step(); d_req = 0; m_addr_ok = 0;
        #2 rst = 0; m_data_ok = 1; m_rdata = 32'hCAFEF00D;
        #1 chk("async_rst", {busy, m_req, d_data_ok, d_rdata, m_addr}, 0);
        step(); rst = 1; m_data_ok = 0;
        i_req = 1; i_addr = 32'h44;
        auto_cycles(6, 0);
        chk("post_rst_counts", {n_ddok[7:0], n_idok[7:0], n_iaok[7:0]}, 24'h000101);

        // Randomized traffic with a random memory.
        for (int c = 0; c < 3000; c++) begin
            m_addr_ok = $urandom_range(0, 1);
            m_data_ok = ($urandom_range(0, 2) == 0);
            m_rdata   = $urandom;
            #1; hi = i_addr_ok; hd = d_addr_ok;
            step();
            if (!i_req || hi) begin
                i_req  = ($urandom_range(0, 2) == 0);
                i_addr = $urandom;
            end
            if (!d_req || hd) begin
                d_req   = ($urandom_range(0, 2) == 0);
                d_wr    = $urandom_range(0, 1);
                d_size  = $urandom_range(0, 2);
                d_wstrb = $urandom;
                d_addr  = $urandom;
                d_wdata = $urandom;
            end
        end
        step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_bus_arbiter.md
MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 Parameter: AW, 32, address width of all address ports.
REQ-002 clk  in  1  system clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, asynchronous assert, active-low (0 = reset).
REQ-004 i_req  in  1  instruction-fetch request, held until i_addr_ok.
REQ-005 i_addr  in  AW  fetch address (always a 4-byte read).
REQ-006 i_addr_ok  out  1  fetch request accepted by memory.
REQ-007 i_data_ok  out  1  fetch data valid on i_rdata.
REQ-008 i_rdata  out  32  fetch read data.
REQ-009 d_req  in  1  data request from MEM stage, held until d_addr_ok.
REQ-010 d_wr  in  1  1 = store, 0 = load.
REQ-011 d_size  in  2  access size (0 byte, 1 half, 2 word).
REQ-012 d_wstrb  in  4  byte write enables.
REQ-013 d_addr  in  AW  data address.
REQ-014 d_wdata  in  32  store data.
REQ-015 d_addr_ok, d_data_ok  out  1 each  data-side accept / completion.
REQ-016 d_rdata  out  32  load data.
REQ-017 m_req, m_wr  out  1 each  memory-port request and direction.
REQ-018 m_size, m_wstrb, m_addr, m_wdata  out  2/4/AW/32  registered payload of granted requester.
REQ-019 m_addr_ok, m_data_ok  in  1 each  memory-port accept / completion.
REQ-020 m_rdata  in  32  memory read data.
REQ-021 busy  out  1  high whenever FSM is not IDLE.

Function
REQ-022 FSM states: IDLE, ADDR, WAIT; a 1-bit owner register (0 = I, 1 = D) is held from grant until completion.
REQ-023 IDLE: if d_req or i_req is high at the edge, latch the winner's payload (I: m_wr=0, m_size=2, m_wstrb=0), set owner, and go to ADDR.
REQ-024 Priority without the configuration macro: d_req wins over i_req on simultaneous requests.
REQ-025 ADDR: m_req=1; i_addr_ok/d_addr_ok = m_addr_ok gated by owner, combinational, one-cycle pulse; on m_addr_ok go to WAIT, or go to IDLE if m_data_ok is high in the same cycle.
REQ-026 WAIT: m_req=0; on m_data_ok pulse the owner's data_ok the same cycle, then go to IDLE.
REQ-027 i_rdata and d_rdata are driven continuously from m_rdata; validity is indicated only by the corresponding data_ok.
REQ-028 Latency: request at edge N gives m_req high in cycle N+1; minimum turnaround is 2 cycles per transaction, with one IDLE cycle between transactions.
REQ-029 Exactly one transaction is outstanding at a time; requests arriving in ADDR or WAIT are not accepted until IDLE.
REQ-030 A non-owner never receives addr_ok or data_ok; m_data_ok in IDLE or ADDR (not co-incident with accept) is ignored.
REQ-031 Stores complete on m_data_ok exactly as loads do; m_rdata is don't-care.

Reset
REQ-032 When rst=0: FSM goes to IDLE, owner=0, last-grant=0, all outputs are 0; an in-flight transaction is dropped with no data_ok generated.
REQ-033 Release of rst is synchronous to clk; the first grant is possible at the first edge after release.

Configuration
REQ-034 Macro MEM_ARB_RR_EN defined: on simultaneous requests, the requester not granted last wins, with last-grant updated at each grant; single requests are granted unchanged.
REQ-035 Macro MEM_ARB_RR_EN undefined: fixed data priority (REQ-024); the last-grant register is not present.

Verification
REQ-036 Verification: d_req load addr 0x1000 alone, m_addr_ok 1 cycle after m_req, m_data_ok after 3 cycles with m_rdata 0xDEADBEEF -> one d_addr_ok pulse, one d_data_ok pulse, d_rdata 0xDEADBEEF, i_* silent.
REQ-037 Verification: i_req and d_req raised in the same cycle, macro off -> D granted first, I granted in the IDLE cycle after D completes; with macro on, alternation D, I, D across three back-to-back collisions.
REQ-038 Verification: m_addr_ok and m_data_ok high in the same ADDR cycle -> addr_ok and data_ok pulse together; FSM returns to IDLE; next grant occurs on the following edge.
REQ-039 Verification: store d_wstrb=0x3, d_size=1, d_wdata=0x0000ABCD -> m_wr=1, m_wstrb=0x3, m_wdata=0x0000ABCD held stable from m_req rise until m_addr_ok.
REQ-040 Verification: rst driven low while in WAIT -> all outputs 0 asynchronously, no data_ok; after release, a fresh i_req completes normally.
